i2c_master_bit_engine: RTL and testbench

Bit-level I2C master engine. It consumes the `count` value of the master's free-running slot counter and generates the open-drain SCL/SDA waveforms for START, STOP, byte WRITE and byte READ. It drives the counter's `stretch` and `waiting` controls back to it. Upstream, a command sequencer issues one command at a time over a valid/ready handshake.

---
 rtl/i2c_master_bit_engine.sv | 176 +++++++++++++++++
 tb/tb_i2c_master_bit_engine.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_bit_engine.sv
// Bit-level I2C master: turns slot-counter positions into open-drain SCL/SDA
// waveforms for START, STOP, byte WRITE and byte READ, and steers the counter.
module i2c_master_bit_engine #(
  parameter int PERIOD      = 1000,
  parameter int SYNC_MARGIN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] count,
  output logic       stretch,
  output logic       waiting,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic [7:0] wr_data,
  input  logic       ack_out,
  output logic [7:0] rd_data,
  output logic       ack_in,
  output logic       done,
  output logic       busy,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic [1:0] o_dbg_state
);

  localparam logic [9:0] C_Q    = 10'(PERIOD / 4);
  localparam logic [9:0] C_2Q   = 10'(PERIOD / 2);
  localparam logic [9:0] C_3Q   = 10'(3 * PERIOD / 4);
  localparam logic [9:0] C_LAST = 10'(PERIOD - 1);
  localparam logic [9:0] C_CHK  = 10'(PERIOD / 2 + SYNC_MARGIN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BIT   = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] r_slot;
  logic       r_is_read;
  logic [7:0] r_wr_data;
  logic       r_ack_out;
  logic [7:0] r_rd_data;
  logic       r_ack_in;
  logic       r_done;
  logic       r_scl_oe;
  logic       r_sda_oe;
  logic       r_scl_s1, r_scl_s2;
  logic       r_sda_s1, r_sda_s2;
  logic       w_count_last;
  logic       w_last_slot;
  logic       w_accept;
  logic       w_sda_bit;

  // Handshake: a command transfers on the rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE, so cmd_valid in any other state is ignored.
  assign w_accept     = cmd_valid && (r_state == S_IDLE);
  assign w_count_last = (count == C_LAST);
  assign w_last_slot  = (r_state != S_BIT) || (r_slot == 4'd8);

  always_comb begin
    if (r_slot == 4'd8)
      w_sda_bit = r_is_read ? r_ack_out : 1'b0;
    else
      w_sda_bit = r_is_read ? 1'b0 : ~r_wr_data[3'd7 - r_slot[2:0]];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    cmd_ready    = 1'b0;
    busy         = 1'b0;
    waiting      = 1'b0;
    stretch      = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        waiting   = 1'b1;
        if (cmd_valid) begin
          case (cmd)
            2'b00:   w_next_state = S_START;
            2'b11:   w_next_state = S_STOP;
            default: w_next_state = S_BIT;
          endcase
        end
      end
      default: begin
        busy    = 1'b1;
        waiting = w_count_last;
        // Slave clock stretching: SCL released but still seen low after the sync delay.
        stretch = !w_count_last && (count == C_CHK) && !r_scl_oe && !r_scl_s2;
        if (w_count_last && w_last_slot) w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_scl_s1  <= 1'b1;
      r_scl_s2  <= 1'b1;
      r_sda_s1  <= 1'b1;
      r_sda_s2  <= 1'b1;
      r_slot    <= 4'd0;
      r_is_read <= 1'b0;
      r_wr_data <= 8'd0;
      r_ack_out <= 1'b0;
      r_rd_data <= 8'd0;
      r_ack_in  <= 1'b0;
      r_done    <= 1'b0;
      r_scl_oe  <= 1'b0;
      r_sda_oe  <= 1'b0;
    end else begin
      r_scl_s1 <= scl_in;
      r_scl_s2 <= r_scl_s1;
      r_sda_s1 <= sda_in;
      r_sda_s2 <= r_sda_s1;
      r_done   <= (r_state != S_IDLE) && w_count_last && w_last_slot;
      if (w_accept) begin
        r_wr_data <= wr_data;
        r_ack_out <= ack_out;
        r_is_read <= (cmd == 2'b10);
        r_slot    <= 4'd0;
      end
      case (r_state)
        S_START: begin
          if (count == 10'd0) r_sda_oe <= 1'b0;
          if (count == C_2Q)  r_scl_oe <= 1'b0;
          if (count == C_3Q)  r_sda_oe <= 1'b1;
          if (w_count_last)   r_scl_oe <= 1'b1;
        end
        S_BIT: begin
          if (count == 10'd0) r_scl_oe <= 1'b1;
          if (count == C_Q)   r_sda_oe <= w_sda_bit;
          if (count == C_2Q)  r_scl_oe <= 1'b0;
          if (count == C_3Q) begin
            if (r_is_read) begin
              if (r_slot != 4'd8) r_rd_data <= {r_rd_data[6:0], r_sda_s2};
            end else if (r_slot == 4'd8) begin
              r_ack_in <= ~r_sda_s2;
            end
          end
          // The byte ends with SCL pulled low so the bus is parked safely.
          if (w_count_last) begin
            if (r_slot == 4'd8) r_scl_oe <= 1'b1;
            else                r_slot   <= r_slot + 4'd1;
          end
        end
        S_STOP: begin
          if (count == 10'd0) begin
            r_scl_oe <= 1'b1;
            r_sda_oe <= 1'b1;
          end
          if (count == C_2Q) r_scl_oe <= 1'b0;
          if (count == C_3Q) r_sda_oe <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign scl_oe      = r_scl_oe;
  assign sda_oe      = r_sda_oe;
  assign rd_data     = r_rd_data;
  assign ack_in      = r_ack_in;
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_i2c_master_bit_engine.sv
// Directed bench for i2c_master_bit_engine: slot counter, open-drain bus with a
// slave model, and a scoreboard of expected SDA bits and latencies.
module tb_i2c_master_bit_engine;

  localparam int PERIOD = 1000;
  localparam int Q      = PERIOD / 4;
  localparam int SM     = 4;
  localparam int CHK    = PERIOD / 2 + SM;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [9:0] cnt;
  logic       stretch, waiting, cmd_ready, ack_in, done, busy;
  logic       scl_in, sda_in, scl_oe, sda_oe;
  logic [7:0] rd_data;
  logic [1:0] dbg_state;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd       = 2'b00;
  logic [7:0] wr_data   = 8'h00;
  logic       ack_out   = 1'b0;

  // slave model
  int         sl_arm_id      = 0;
  int         sl_seen_id     = 0;
  logic [8:0] sl_pattern     = 9'h1FF;
  int         sl_stretch_bit = -1;
  int         sl_stretch_len = 50;
  logic       sl_active      = 1'b0;
  logic       sl_sda_low     = 1'b0;
  logic       sl_scl_low     = 1'b0;
  logic       sl_prev_scl    = 1'b1;
  int         sl_idx         = 0;
  int         sl_hold        = 0;

  assign scl_in = ~(scl_oe | sl_scl_low);
  assign sda_in = ~(sda_oe | sl_sda_low);

  i2c_master_bit_engine #(.PERIOD(PERIOD), .SYNC_MARGIN(SM)) dut (
    .clk(clk), .reset(rst_n), .count(cnt), .stretch(stretch), .waiting(waiting),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd), .wr_data(wr_data),
    .ack_out(ack_out), .rd_data(rd_data), .ack_in(ack_in), .done(done), .busy(busy),
    .scl_in(scl_in), .sda_in(sda_in), .scl_oe(scl_oe), .sda_oe(sda_oe),
    .o_dbg_state(dbg_state)
  );

  // free-running slot counter controlled by the engine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt <= 10'd0;
    else if (waiting) cnt <= 10'd0;
    else if (!stretch) cnt <= cnt + 10'd1;
  end

  // slave: drives the next pattern bit after each SCL fall, optional stretch
  always @(posedge clk) begin
    sl_prev_scl <= scl_in;
    if (sl_arm_id != sl_seen_id) begin
      sl_seen_id <= sl_arm_id;
      sl_active  <= 1'b1;
      sl_idx     <= 0;
      sl_sda_low <= !sl_pattern[8];
      sl_scl_low <= (sl_stretch_bit == 0);
      sl_hold    <= 0;
    end else if (sl_active) begin
      if (sl_scl_low && !scl_oe) begin
        if (sl_hold == sl_stretch_len - 1) sl_scl_low <= 1'b0;
        sl_hold <= sl_hold + 1;
      end
      if (sl_prev_scl && !scl_in) begin
        if (sl_idx == 8) begin
          sl_active  <= 1'b0;
          sl_sda_low <= 1'b0;
        end else begin
          sl_idx     <= sl_idx + 1;
          sl_sda_low <= !sl_pattern[7 - sl_idx];
          sl_scl_low <= (sl_stretch_bit == sl_idx + 1);
          sl_hold    <= 0;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int st_cycles, st_bad, both_hi = 0;
  int scl_rise, scl_fall, sda_rise, sda_fall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_bits(input logic [8:0] bits);
    for (int i = 8; i >= 0; i--) exp_q.push_back(32'(bits[i]));
  endtask

  task automatic check_bits(input string tag);
    logic [31:0] o, e;
    for (int i = 0; i < 9; i++) begin
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hDEAD;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hBEEF;
      check(tag, o, e);
    end
  endtask

  task automatic arm_slave(input logic [8:0] pat, input int st_bit);
    sl_pattern     = pat;
    sl_stretch_bit = st_bit;
    sl_arm_id      = sl_arm_id + 1;
  endtask

  // ---------------- driver ----------------
  task automatic run_cmd(input logic [1:0] c, input logic [7:0] d, input logic a,
                         input int abort_slot, output int lat, output bit aborted);
    int cyc, slots;
    logic [9:0] pc;
    logic ps, pd;
    logic [1:0] pst;
    cyc = 0;
    while (!cmd_ready && cyc < 100) begin @(negedge clk); cyc++; end
    cmd = c; wr_data = d; ack_out = a; cmd_valid = 1'b1;
    st_cycles = 0; st_bad = 0; obs_q.delete();
    scl_rise = -1; scl_fall = -1; sda_rise = -1; sda_fall = -1;
    pc = cnt; ps = scl_oe; pd = sda_oe; pst = dbg_state;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    cyc = 0; lat = -1; aborted = 1'b0; slots = 0;
    while (cyc < 12000) begin
      @(negedge clk);
      cyc++;
      if (scl_oe && !ps) scl_rise = int'(pc);
      if (!scl_oe && ps) scl_fall = int'(pc);
      if (sda_oe && !pd) sda_rise = int'(pc);
      if (!sda_oe && pd) sda_fall = int'(pc);
      if (pst == 2'd2 && pc == 10'(Q)) begin
        obs_q.push_back(32'(sda_oe));
        slots++;
      end
      if (stretch) begin
        st_cycles++;
        if (cnt != 10'(CHK)) st_bad++;
      end
      if (stretch && waiting) both_hi++;
      if (abort_slot >= 0 && slots == abort_slot + 1 && cnt == 10'd300) begin
        rst_n = 1'b0;
        aborted = 1'b1;
        break;
      end
      if (done) begin
        lat = cyc;
        break;
      end
      pc = cnt; ps = scl_oe; pd = sda_oe; pst = dbg_state;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    bit ab;
    #3 rst_n = 1'b0;
    #1;
    check("rst_scl_oe", 32'(scl_oe), 0);
    check("rst_sda_oe", 32'(sda_oe), 0);
    check("rst_state", 32'(dbg_state), 0);
    check("rst_waiting", 32'(waiting), 1);
    check("rst_stretch", 32'(stretch), 0);
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_ack_in", 32'(ack_in), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // START
    exp_q.push_back(32'd1001);
    run_cmd(2'b00, 8'h00, 1'b0, -1, lat, ab);
    check("start_latency", 32'(lat), exp_q.pop_front());
    check("start_sda_rise", 32'(sda_rise), 750);
    check("start_scl_rise", 32'(scl_rise), 999);
    check("start_lines", {30'd0, scl_oe, sda_oe}, 3);

    // WRITE 0xA5, slave ACK
    arm_slave({8'hFF, 1'b0}, -1);
    expect_bits({~8'hA5, 1'b0});
    run_cmd(2'b01, 8'hA5, 1'b0, -1, lat, ab);
    check_bits("wr_a5_sda_bit");
    check("wr_a5_latency", 32'(lat), 9001);
    check("wr_a5_ack_in", 32'(ack_in), 1);
    check("wr_a5_scl_held", 32'(scl_oe), 1);
    check("wr_a5_no_stretch", 32'(st_cycles), 0);

    // READ 0x3C, master NACK
    arm_slave({8'h3C, 1'b1}, -1);
    expect_bits({8'h00, 1'b0});
    run_cmd(2'b10, 8'h00, 1'b0, -1, lat, ab);
    check_bits("rd_3c_sda_bit");
    check("rd_3c_rd_data", 32'(rd_data), 32'h3C);
    check("rd_3c_latency", 32'(lat), 9001);
    check("rd_3c_scl_held", 32'(scl_oe), 1);
    check("rd_3c_ack_in_hold", 32'(ack_in), 1);

    // READ 0x96, master ACK
    arm_slave({8'h96, 1'b1}, -1);
    expect_bits({8'h00, 1'b1});
    run_cmd(2'b10, 8'h00, 1'b1, -1, lat, ab);
    check_bits("rd_96_sda_bit");
    check("rd_96_rd_data", 32'(rd_data), 32'h96);
    check("rd_96_sda_held", 32'(sda_oe), 1);

    // WRITE 0x5A, slave stretches slot 3 and NACKs
    arm_slave({8'hFF, 1'b1}, 3);
    expect_bits({~8'h5A, 1'b0});
    run_cmd(2'b01, 8'h5A, 1'b0, -1, lat, ab);
    check_bits("wr_5a_sda_bit");
    check("wr_5a_ack_in", 32'(ack_in), 0);
    check("stretch_len_range", 32'(st_cycles >= 40 && st_cycles <= 52), 1);
    check("stretch_count_504", 32'(st_bad), 0);
    check("stretch_extra_latency", 32'(lat - 9001), 32'(st_cycles));

    // STOP
    run_cmd(2'b11, 8'h00, 1'b0, -1, lat, ab);
    check("stop_latency", 32'(lat), 1001);
    check("stop_scl_fall", 32'(scl_fall), 500);
    check("stop_sda_fall", 32'(sda_fall), 750);
    @(negedge clk);
    check("stop_lines", {30'd0, scl_oe, sda_oe}, 0);
    check("stop_busy", 32'(busy), 0);

    // START, then READ interrupted by reset in slot 5
    run_cmd(2'b00, 8'h00, 1'b0, -1, lat, ab);
    check("start2_latency", 32'(lat), 1001);
    arm_slave({8'hF0, 1'b1}, -1);
    run_cmd(2'b10, 8'h00, 1'b0, 5, lat, ab);
    check("abort_reached", 32'(ab), 1);
    #1;
    check("abort_scl_oe", 32'(scl_oe), 0);
    check("abort_sda_oe", 32'(sda_oe), 0);
    check("abort_state", 32'(dbg_state), 0);
    check("abort_waiting", 32'(waiting), 1);
    check("abort_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    arm_slave(9'h1FF, -1);
    @(negedge clk);
    run_cmd(2'b00, 8'h00, 1'b0, -1, lat, ab);
    check("post_reset_start_latency", 32'(lat), 1001);
    check("post_reset_sda_rise", 32'(sda_rise), 750);
    check("post_reset_rd_data", 32'(rd_data), 0);
    check("stretch_waiting_overlap", 32'(both_hi), 0);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
